// File: rtl/muldiv_pkg.sv
// Shared M-extension constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'h01;

  typedef enum logic [2:0] {
    mul_conf    = 3'd0,
    mulh_conf   = 3'd1,
    mulhsu_conf = 3'd2,
    mulhu_conf  = 3'd3,
    div_conf    = 3'd4,
    divu_conf   = 3'd5,
    rem_conf    = 3'd6,
    remu_conf   = 3'd7
  } muldiv_conf;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state;

  typedef enum logic [1:0] {
    FIX_OPERAND_A = 2'd0,
    FIX_OPERAND_B = 2'd1,
    FIX_RESULT    = 2'd2
  } signfix_role;

  function automatic logic is_muldiv_funct7(input logic [6:0] funct7);
    return funct7 == MULDIV_FUNCT7;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Op signedness decode plus conditional two's-complement negation, used both to
// take operand magnitudes and to restore the sign of the finished result.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter signfix_role ROLE  = FIX_RESULT
) (
  input  muldiv_conf       op_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             sign_a_i,
  input  logic             sign_b_i,
  output logic [WIDTH-1:0] value_o
);

  logic a_signed;
  logic b_signed;
  logic is_rem;
  logic negate;

  assign a_signed = (op_i == mulh_conf) || (op_i == mulhsu_conf) ||
                    (op_i == div_conf)  || (op_i == rem_conf);
  assign b_signed = (op_i == mulh_conf) || (op_i == div_conf) || (op_i == rem_conf);
  assign is_rem   = (op_i == rem_conf)  || (op_i == remu_conf);

  // Remainders follow the dividend; products and quotients follow the sign xor.
  always_comb begin
    negate = 1'b0;
    case (ROLE)
      FIX_OPERAND_A: negate = a_signed & sign_a_i;
      FIX_OPERAND_B: negate = b_signed & sign_b_i;
      default: negate = is_rem ? (a_signed & sign_a_i)
                               : ((a_signed & sign_a_i) ^ (b_signed & sign_b_i));
    endcase
  end

  assign value_o = negate ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  kill_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state state_q, state_d;
  muldiv_conf  op_in, op_q;
  logic [DATA_WIDTH-1:0]   a_mag_in, b_mag_in, a_mag_q, b_mag_q;
  logic                    sign_a_q, sign_b_q;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_step, res_raw, res_fixed;
  logic [CNT_W-1:0]        cnt_q;
  logic                    accept, is_special, cnt_done;
  logic [DATA_WIDTH-1:0]   special_val, result_sel;
  logic [DATA_WIDTH:0]     add_sum, div_shift, div_diff;

  assign op_in    = muldiv_conf'(op_i);
  assign accept   = (state_q == IDLE) & valid_i & ~kill_i;
  assign cnt_done = (cnt_q == CNT_W'(DATA_WIDTH));

  muldiv_signfix #(.WIDTH(DATA_WIDTH), .ROLE(FIX_OPERAND_A)) u_fix_a (
    .op_i(op_in), .value_i(rs1_i), .sign_a_i(rs1_i[DATA_WIDTH-1]),
    .sign_b_i(rs2_i[DATA_WIDTH-1]), .value_o(a_mag_in)
  );

  muldiv_signfix #(.WIDTH(DATA_WIDTH), .ROLE(FIX_OPERAND_B)) u_fix_b (
    .op_i(op_in), .value_i(rs2_i), .sign_a_i(rs1_i[DATA_WIDTH-1]),
    .sign_b_i(rs2_i[DATA_WIDTH-1]), .value_o(b_mag_in)
  );

  // Divide-by-zero and most-negative / -1 finish on the accept edge.
  always_comb begin
    is_special  = 1'b0;
    special_val = '0;
    if (op_i[2]) begin
      if (rs2_i == '0) begin
        is_special  = 1'b1;
        special_val = op_i[1] ? rs1_i : '1;
      end else if (!op_i[0] && rs1_i == MOST_NEG && rs2_i == '1) begin
        is_special  = 1'b1;
        special_val = op_i[1] ? '0 : MOST_NEG;
      end
    end
  end

  // Multiply keeps the multiplier in the low half and shifts right; divide keeps
  // the partial remainder in the high half and shifts quotient bits in from the right.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    div_shift = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (op_q[2])
      acc_step = {(div_diff[DATA_WIDTH] ? div_shift[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0]),
                  acc_q[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
    else
      acc_step = {add_sum, acc_q[DATA_WIDTH-1:1]};
  end

  assign res_raw = op_q[2] ? {{DATA_WIDTH{1'b0}},
                              (op_q[1] ? acc_q[2*DATA_WIDTH-1:DATA_WIDTH] : acc_q[DATA_WIDTH-1:0])}
                           : acc_q;

  muldiv_signfix #(.WIDTH(2*DATA_WIDTH), .ROLE(FIX_RESULT)) u_fix_res (
    .op_i(op_q), .value_i(res_raw), .sign_a_i(sign_a_q),
    .sign_b_i(sign_b_q), .value_o(res_fixed)
  );

  assign result_sel = (op_q[2] || op_q == mul_conf) ? res_fixed[DATA_WIDTH-1:0]
                                                    : res_fixed[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_special ? DONE : BUSY;
      BUSY: begin
        if (kill_i)        state_d = IDLE;
        else if (cnt_done) state_d = DONE;
      end
      DONE: if (kill_i || ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
    busy_o  = (state_q != IDLE);
  end

  // The extra cycle at cnt == DATA_WIDTH registers the sign-fixed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= mul_conf;
      tag_o    <= '0;
      result_o <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      tag_o    <= tag_i;
      a_mag_q  <= a_mag_in;
      b_mag_q  <= b_mag_in;
      sign_a_q <= rs1_i[DATA_WIDTH-1];
      sign_b_q <= rs2_i[DATA_WIDTH-1];
      cnt_q    <= '0;
      acc_q    <= op_i[2] ? {{DATA_WIDTH{1'b0}}, a_mag_in} : {{DATA_WIDTH{1'b0}}, b_mag_in};
      if (is_special) result_o <= special_val;
    end else if (state_q == BUSY && !kill_i) begin
      if (cnt_done) begin
        result_o <= result_sel;
      end else begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at 32-bit and 8-bit data widths.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i, ready_o, kill_i, valid_o, ready_i, busy_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i, result_o;
  logic [4:0]  tag_i, tag_o;

  logic        v8_valid_i, v8_ready_o, v8_kill_i, v8_valid_o, v8_ready_i, v8_busy_o;
  logic [2:0]  v8_op_i;
  logic [7:0]  v8_rs1_i, v8_rs2_i, v8_result_o;
  logic [4:0]  v8_tag_i, v8_tag_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i), .kill_i(kill_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  muldiv_unit #(.DATA_WIDTH(8), .TAG_WIDTH(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_i(v8_valid_i), .ready_o(v8_ready_o), .op_i(v8_op_i),
    .rs1_i(v8_rs1_i), .rs2_i(v8_rs2_i), .tag_i(v8_tag_i), .kill_i(v8_kill_i),
    .valid_o(v8_valid_o), .ready_i(v8_ready_i), .result_o(v8_result_o), .tag_o(v8_tag_o),
    .busy_o(v8_busy_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Counts edges after the accept edge until valid_o is seen; gives up after 100.
  task automatic waitValid(output int edges, output bit ready_low_ok);
    edges = 0;
    ready_low_ok = 1'b1;
    while (!valid_o && edges < 100) begin
      if (ready_o) ready_low_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int edges;
    bit low_ok;
    @(negedge clk);
    op_i = v.op; rs1_i = v.a; rs2_i = v.b; tag_i = v.tag;
    valid_i = 1'b1; ready_i = 1'b1;
    checkOutput({v.name, "_ready_idle"}, {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = ~v.op; rs1_i = ~v.a; rs2_i = 32'h5; tag_i = ~v.tag;
    waitValid(edges, low_ok);
    checkOutput({v.name, "_latency"}, edges, v.lat);
    checkOutput({v.name, "_result"}, result_o, v.exp);
    checkOutput({v.name, "_tag"}, {27'd0, tag_o}, {27'd0, v.tag});
    checkOutput({v.name, "_ready_low"}, {31'd0, low_ok}, 32'd1);
    @(posedge clk); #1;
    checkOutput({v.name, "_back_idle"}, {30'd0, ready_o, valid_o}, 32'd2);
  endtask

  task automatic applyStimulus8(input string name, input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] exp, input int lat);
    int edges;
    @(negedge clk);
    v8_op_i = op; v8_rs1_i = a; v8_rs2_i = b; v8_tag_i = 5'd3;
    v8_valid_i = 1'b1; v8_ready_i = 1'b1;
    @(posedge clk); #1;
    v8_valid_i = 1'b0; v8_rs1_i = 8'h00; v8_rs2_i = 8'h00;
    edges = 0;
    while (!v8_valid_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, "_latency"}, edges, lat);
    checkOutput({name, "_result"}, {24'd0, v8_result_o}, {24'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    int  edges;
    bit  low_ok;
    bit  seen;
    vec_t mul34;

    vecs = '{
      '{"mul_7_m3",     mul_conf,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33},
      '{"mulh_min_2",   mulh_conf,   32'h80000000, 32'd2,        5'd1,  32'hFFFFFFFF, 33},
      '{"mulhu_min_2",  mulhu_conf,  32'h80000000, 32'd2,        5'd2,  32'h00000001, 33},
      '{"mulhsu_m1",    mulhsu_conf, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33},
      '{"mul_m5_m6",    mul_conf,    32'hFFFFFFFB, 32'hFFFFFFFA, 5'd4,  32'h0000001E, 33},
      '{"mulh_m5_m6",   mulh_conf,   32'hFFFFFFFB, 32'hFFFFFFFA, 5'd6,  32'h00000000, 33},
      '{"div_7_m2",     div_conf,    32'd7,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFD, 33},
      '{"rem_7_m2",     rem_conf,    32'd7,        32'hFFFFFFFE, 5'd8,  32'h00000001, 33},
      '{"divu_big_2",   divu_conf,   32'hFFFFFFFE, 32'd2,        5'd9,  32'h7FFFFFFF, 33},
      '{"remu_10_3",    remu_conf,   32'd10,       32'd3,        5'd10, 32'h00000001, 33},
      '{"div_m7_2",     div_conf,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 33},
      '{"rem_m7_2",     rem_conf,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 33},
      '{"div_by_zero",  div_conf,    32'd42,       32'd0,        5'd13, 32'hFFFFFFFF, 0},
      '{"rem_by_zero",  rem_conf,    32'd42,       32'd0,        5'd14, 32'd42,       0},
      '{"div_overflow", div_conf,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0},
      '{"rem_overflow", rem_conf,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 0},
      '{"remu_by_zero", remu_conf,   32'd42,       32'd0,        5'd17, 32'd42,       0},
      '{"divu_by_zero", divu_conf,   32'd42,       32'd0,        5'd18, 32'hFFFFFFFF, 0}
    };
    mul34 = '{"mul_3_4", mul_conf, 32'd3, 32'd4, 5'd9, 32'd12, 33};

    valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1; op_i = 3'd0;
    rs1_i = '0; rs2_i = '0; tag_i = '0;
    v8_valid_i = 1'b0; v8_kill_i = 1'b0; v8_ready_i = 1'b1; v8_op_i = 3'd0;
    v8_rs1_i = '0; v8_rs2_i = '0; v8_tag_i = '0;

    #2;
    checkOutput("reset_flags", {29'd0, ready_o, valid_o, busy_o}, 32'h4);
    checkOutput("reset_result", result_o, 32'd0);
    checkOutput("reset_tag", {27'd0, tag_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 18; i++) applyStimulus(vecs[i]);

    // Back-pressure: the result must sit still while the consumer stalls.
    @(negedge clk);
    op_i = mul_conf; rs1_i = 32'd3; rs2_i = 32'd4; tag_i = 5'd9; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1; valid_i = 1'b0;
    waitValid(edges, low_ok);
    checkOutput("bp_latency", edges, 33);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_result", result_o, 32'd12);
      checkOutput("bp_hold_flags", {30'd0, valid_o, ready_o}, 32'd2);
    end
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release", {30'd0, ready_o, valid_o}, 32'd2);

    // Kill on the 12th BUSY cycle drops the operation without a result.
    @(negedge clk);
    op_i = mul_conf; rs1_i = 32'd5; rs2_i = 32'd6; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); kill_i = 1'b1;
    @(posedge clk); #1; kill_i = 1'b0;
    checkOutput("kill_to_idle", {29'd0, ready_o, valid_o, busy_o}, 32'h4);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    checkOutput("kill_no_valid", {31'd0, seen}, 32'd0);

    // A request presented together with kill is refused.
    @(negedge clk); valid_i = 1'b1; kill_i = 1'b1; op_i = mul_conf;
    @(posedge clk); #1;
    checkOutput("kill_blocks_accept", {31'd0, busy_o}, 32'd0);
    valid_i = 1'b0; kill_i = 1'b0;

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    op_i = mul_conf; rs1_i = 32'd9; rs2_i = 32'd9; tag_i = 5'd21; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_flags", {29'd0, ready_o, valid_o, busy_o}, 32'h4);
    checkOutput("async_reset_result", result_o, 32'd0);
    checkOutput("async_reset_tag", {27'd0, tag_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(mul34);

    applyStimulus8("w8_mul_ff_ff", mul_conf,   8'hFF, 8'hFF, 8'h01, 9);
    applyStimulus8("w8_mulhu_ff",  mulhu_conf, 8'hFF, 8'hFF, 8'hFE, 9);
    applyStimulus8("w8_divu_200_7", divu_conf, 8'hC8, 8'h07, 8'h1C, 9);
    applyStimulus8("w8_rem_m7_2",  rem_conf,   8'hF9, 8'h02, 8'hFF, 9);
    applyStimulus8("w8_div_ovf",   div_conf,   8'h80, 8'hFF, 8'h80, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
